transceiver_spi_arbiter: RTL and testbench
==========================================

Name: transceiver_spi_arbiter

Overview:
Shares the single SPI byte engine that drives the radio transceiver's SS/MOSI/SCLK/MISO lines between N_REQ requesters (config loader, TX packet writer, status poller). Grants are round-robin. A grant locks to one requester for a multi-byte transaction, which ends on that requester's LAST byte. Sits between the requesters and the SPI byte engine inside transceiver_integration. Controls chip-select framing, enforces a minimum SS-high gap, and aborts stalled transactions with a watchdog.

Parameters:
N_REQ, 3, number of requesters
TIMEOUT_CYCLES, 255, max idle cycles in HOLD before abort
GAP_CYCLES, 4, min cycles SPI_SEL low between transactions
CNT_W, 8, width of timeout/gap counter (must hold max of both)

Ports:
CLK_48MHZ  in  1  system clock, 48 MHz
RESET  in  1  synchronous, active-high reset
REQ  in  N_REQ  per-requester byte request; held until ACK
TX_DATA  in  8*N_REQ  byte per requester; slice i = [8i+7:8i]
LAST  in  N_REQ  byte is final of transaction
GNT  out  N_REQ  one-hot current owner
ACK  out  N_REQ  one-cycle pulse, byte complete, RX_DATA valid
RX_DATA  out  8  byte received for last ACKed transfer
TIMEOUT_ERR  out  N_REQ  one-cycle pulse, owner's transaction aborted
SPI_SEL  out  1  level; engine drives SS low while high
SPI_START  out  1  one-cycle start pulse to byte engine
SPI_TX_BYTE  out  8  byte to shift; stable from START until DONE
SPI_BUSY  in  1  engine busy
SPI_DONE  in  1  one-cycle byte-complete pulse
SPI_RX_BYTE  in  8  byte shifted in; valid with SPI_DONE

Behaviour:
- All outputs are registered. On reset, all outputs are 0, state is IDLE, counter is 0, and the RR pointer is last_owner = N_REQ-1, so requester 0 has first priority.
- IDLE, any REQ high:
  - Select the first requesting index, searching from last_owner+1 with wrap.
  - Next edge: GNT[sel]=1, SPI_SEL=1, latch TX_DATA[sel] and LAST[sel], last_owner=sel, go to ISSUE.
- ISSUE:
  - If !SPI_BUSY, next edge: SPI_START=1 for one cycle, SPI_TX_BYTE=latched byte, go to WAIT_DONE.
  - Otherwise stay in ISSUE; START is never issued while BUSY.
  - SPI_SEL is therefore high at least one cycle before START.
- WAIT_DONE, SPI_DONE high:
  - Next edge: ACK[owner]=1 for one cycle, RX_DATA=SPI_RX_BYTE.
  - Latched LAST=1: go to RELEASE.
  - Otherwise: go to HOLD with counter cleared.
- HOLD:
  - REQ is ignored during the ACK cycle; the requester updates TX_DATA/LAST or drops REQ by the cycle after ACK.
  - REQ[owner] high: latch data/LAST, go to ISSUE. SPI_SEL stays high, so bytes are framed under one SS.
  - Otherwise the counter increments. At counter == TIMEOUT_CYCLES-1, next edge: TIMEOUT_ERR[owner] pulse, go to RELEASE.
  - Requests from other requesters are ignored in HOLD.
- RELEASE:
  - On entry, GNT=0, SPI_SEL=0, counter cleared.
  - Stay GAP_CYCLES cycles, then go to IDLE. No new grant before the gap completes.
- Fixed latencies:
  - REQ to GNT: 1 cycle.
  - GNT to START: 1 cycle when not busy.
  - DONE to ACK: 1 cycle.
- SPI_DONE outside WAIT_DONE is ignored. A DONE in the same cycle START is issued is ignored.
- A non-owner REQ is never ACKed. REQ deasserted in ISSUE or WAIT_DONE is ignored; the latched byte completes.
- Reset mid-transaction: next edge returns to reset values. SPI_SEL drops immediately. A late SPI_DONE is ignored.

Test Plan:
1. Two-byte transaction on requester 0: REQ[0] with 0x0A LAST=0, then 0x5C LAST=1; engine returns 0xF0, 0x0F.
   -> Two START pulses with SPI_TX_BYTE 0x0A then 0x5C.
   -> SPI_SEL high continuously across both bytes.
   -> ACK[0] twice, RX_DATA 0xF0 then 0x0F.
   -> SPI_SEL low exactly 4 cycles before IDLE.
2. After reset, REQ=3'b111, single byte each (LAST=1).
   -> GNT order 001, 010, 100.
   -> SPI_SEL low >=4 cycles between transactions.
   -> Exactly 3 ACKs, one per requester.
3. Owner 1 just released; REQ=3'b011.
   -> Grant 0 first (search starts at 2, wraps to 0), then 1.
4. REQ[2] sends 0x33 LAST=0, then drops REQ.
   -> ACK[2] pulse.
   -> 255 cycles later, TIMEOUT_ERR[2] one-cycle pulse.
   -> GNT=0, SPI_SEL=0, no further START.
5. SPI_BUSY high for 10 cycles while in ISSUE.
   -> START asserted exactly once, on the edge after BUSY first samples low.
   -> SPI_TX_BYTE unchanged throughout.
6. RESET during WAIT_DONE, followed by a stale SPI_DONE, then REQ=3'b100.
   -> All outputs 0 one edge after RESET.
   -> No ACK from the stale DONE.
   -> GNT=100 one cycle after REQ.

Source files
------------

// File: rtl/transceiver_spi_arbiter.sv
// Round-robin arbiter sharing one SPI byte engine among N_REQ requesters.
// Grants lock for a multi-byte transaction framed under one SPI_SEL, with gap and watchdog.
module transceiver_spi_arbiter #(
  parameter int N_REQ          = 3,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int GAP_CYCLES     = 4,
  parameter int CNT_W          = 8
) (
  input  logic                 CLK_48MHZ,
  input  logic                 RESET,
  input  logic [N_REQ-1:0]     REQ,
  input  logic [8*N_REQ-1:0]   TX_DATA,
  input  logic [N_REQ-1:0]     LAST,
  output logic [N_REQ-1:0]     GNT,
  output logic [N_REQ-1:0]     ACK,
  output logic [7:0]           RX_DATA,
  output logic [N_REQ-1:0]     TIMEOUT_ERR,
  output logic                 SPI_SEL,
  output logic                 SPI_START,
  output logic [7:0]           SPI_TX_BYTE,
  input  logic                 SPI_BUSY,
  input  logic                 SPI_DONE,
  input  logic [7:0]           SPI_RX_BYTE,
  output logic [2:0]           DBG_STATE
);

  // Handshake: a requester holds REQ with TX_DATA/LAST until its ACK pulse;
  // the byte engine takes SPI_START only while !SPI_BUSY and answers with SPI_DONE.
  localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_WAIT_DONE = 3'd2,
    S_HOLD      = 3'd3,
    S_RELEASE   = 3'd4
  } state_t;

  state_t             r_state;
  logic [OW-1:0]      r_last_owner;
  logic [7:0]         r_byte;
  logic               r_last;
  logic [CNT_W-1:0]   r_cnt;
  logic [N_REQ-1:0]   r_gnt;
  logic [N_REQ-1:0]   r_ack;
  logic [N_REQ-1:0]   r_terr;
  logic [7:0]         r_rx;
  logic               r_sel;
  logic               r_start;
  logic [7:0]         r_tx_byte;

  logic [OW-1:0]      w_sel;
  logic [OW-1:0]      w_cand;
  logic               w_found;
  logic [OW-1:0]      w_mux_idx;
  logic [7:0]         w_tx_mux;
  logic [N_REQ-1:0]   w_one;

  assign w_one = {{(N_REQ-1){1'b0}}, 1'b1};

  // First requester searching upward from last_owner+1, wrapping.
  always_comb begin
    w_sel   = '0;
    w_cand  = '0;
    w_found = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_cand = OW'((int'(r_last_owner) + k) % N_REQ);
      if (!w_found && REQ[w_cand]) begin
        w_found = 1'b1;
        w_sel   = w_cand;
      end
    end
  end

  // In IDLE the candidate is loaded; afterwards the owner is last_owner.
  assign w_mux_idx = (r_state == S_IDLE) ? w_sel : r_last_owner;

  always_comb begin
    w_tx_mux = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (OW'(k) == w_mux_idx) w_tx_mux = TX_DATA[k*8 +: 8];
    end
  end

  always_ff @(posedge CLK_48MHZ) begin
    if (RESET) begin
      r_state      <= S_IDLE;
      r_last_owner <= OW'(N_REQ-1);
      r_byte       <= '0;
      r_last       <= 1'b0;
      r_cnt        <= '0;
      r_gnt        <= '0;
      r_ack        <= '0;
      r_terr       <= '0;
      r_rx         <= '0;
      r_sel        <= 1'b0;
      r_start      <= 1'b0;
      r_tx_byte    <= '0;
    end else begin
      r_start <= 1'b0;
      r_ack   <= '0;
      r_terr  <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_gnt        <= w_one << w_sel;
            r_sel        <= 1'b1;
            r_byte       <= w_tx_mux;
            r_last       <= LAST[w_sel];
            r_last_owner <= w_sel;
            r_state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (!SPI_BUSY) begin
            r_start   <= 1'b1;
            r_tx_byte <= r_byte;
            r_state   <= S_WAIT_DONE;
          end
        end
        S_WAIT_DONE: begin
          // A DONE coinciding with our own START pulse belongs to no byte of ours.
          if (SPI_DONE && !r_start) begin
            r_ack <= r_gnt;
            r_rx  <= SPI_RX_BYTE;
            r_cnt <= '0;
            if (r_last) begin
              r_gnt   <= '0;
              r_sel   <= 1'b0;
              r_state <= S_RELEASE;
            end else begin
              r_state <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (!(|r_ack) && |(REQ & r_gnt)) begin
            r_byte  <= w_tx_mux;
            r_last  <= LAST[r_last_owner];
            r_state <= S_ISSUE;
          end else if (r_cnt == CNT_W'(TIMEOUT_CYCLES-1)) begin
            r_terr  <= r_gnt;
            r_gnt   <= '0;
            r_sel   <= 1'b0;
            r_cnt   <= '0;
            r_state <= S_RELEASE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_RELEASE: begin
          if (r_cnt == CNT_W'(GAP_CYCLES-1)) r_state <= S_IDLE;
          else                               r_cnt   <= r_cnt + 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign GNT         = r_gnt;
  assign ACK         = r_ack;
  assign RX_DATA     = r_rx;
  assign TIMEOUT_ERR = r_terr;
  assign SPI_SEL     = r_sel;
  assign SPI_START   = r_start;
  assign SPI_TX_BYTE = r_tx_byte;
  assign DBG_STATE   = r_state;

endmodule

// File: tb/tb_transceiver_spi_arbiter.sv
// Directed bench for transceiver_spi_arbiter: framing, round-robin order,
// gap, watchdog abort, busy back-pressure and reset mid-transaction.
module tb_transceiver_spi_arbiter;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RELEASE = 3'd4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  req = '0;
  logic [23:0] tx_data = '0;
  logic [2:0]  last = '0;
  logic        spi_busy = 1'b0;
  logic        spi_done = 1'b0;
  logic [7:0]  spi_rx_byte = '0;
  logic [2:0]  gnt, ack, terr;
  logic [7:0]  rx_data, spi_tx_byte;
  logic        spi_sel, spi_start;
  logic [2:0]  dbg_state;

  transceiver_spi_arbiter dut (
    .CLK_48MHZ   (clk),
    .RESET       (rst),
    .REQ         (req),
    .TX_DATA     (tx_data),
    .LAST        (last),
    .GNT         (gnt),
    .ACK         (ack),
    .RX_DATA     (rx_data),
    .TIMEOUT_ERR (terr),
    .SPI_SEL     (spi_sel),
    .SPI_START   (spi_start),
    .SPI_TX_BYTE (spi_tx_byte),
    .SPI_BUSY    (spi_busy),
    .SPI_DONE    (spi_done),
    .SPI_RX_BYTE (spi_rx_byte),
    .DBG_STATE   (dbg_state)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Event counters sampled mid-cycle.
  int   n_start = 0, n_ack = 0, sel_drops = 0, low_run = 0, last_low_run = 0;
  logic prev_sel = 1'b0;
  always @(negedge clk) begin
    n_start = n_start + int'(spi_start);
    n_ack   = n_ack + $countones(ack);
    if (prev_sel && !spi_sel) sel_drops = sel_drops + 1;
    if (!spi_sel) low_run = low_run + 1;
    else begin
      if (low_run != 0) last_low_run = low_run;
      low_run = 0;
    end
    prev_sel = spi_sel;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(input string tag, input logic [2:0] exp);
    int n = 0;
    while (gnt == 3'b000 && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_gnt"}, gnt, exp);
  endtask

  task automatic wait_start(input string tag, input logic [7:0] exp_tx);
    int n = 0;
    while (!spi_start && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_start"}, spi_start, 1);
    check({tag, "_tx"}, spi_tx_byte, exp_tx);
  endtask

  // Engine model: busy for ncyc cycles, then DONE with rx; returns at the ACK slot.
  task automatic engine_byte(input string tag, input logic [7:0] rx, input int ncyc,
                             input logic [7:0] exp_tx);
    logic stable = 1'b1;
    spi_busy = 1'b1;
    repeat (ncyc) begin
      tick();
      if (spi_tx_byte !== exp_tx) stable = 1'b0;
    end
    spi_rx_byte = rx;
    spi_done    = 1'b1;
    spi_busy    = 1'b0;
    tick();
    spi_done    = 1'b0;
    spi_rx_byte = '0;
    check({tag, "_txstable"}, stable, 1);
  endtask

  task automatic run_txn(input string tag, input logic [2:0] exp_gnt, input logic [7:0] exp_tx,
                         input logic [7:0] rx, input logic chk_gap);
    wait_gnt(tag, exp_gnt);
    wait_start(tag, exp_tx);
    if (chk_gap) check({tag, "_gap"}, last_low_run >= 4, 1);
    engine_byte(tag, rx, 2, exp_tx);
    check({tag, "_ack"}, ack, exp_gnt);
    check({tag, "_rx"}, rx_data, rx);
    req = req & ~exp_gnt;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit");
    $fatal(1);
  end

  initial begin
    int n, s0, a0, d0;
    logic seen;

    // Reset values
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check("rst_gnt", gnt, 0);
    check("rst_sel", spi_sel, 0);
    check("rst_start", spi_start, 0);
    check("rst_ack", ack, 0);
    check("rst_rx", rx_data, 0);
    check("rst_terr", terr, 0);
    check("rst_state", dbg_state, ST_IDLE);

    // 1: two-byte transaction on requester 0
    s0 = n_start; d0 = sel_drops;
    req = 3'b001; tx_data = 24'h00000A; last = 3'b000;
    tick();
    check("t1_gnt_lat", gnt, 3'b001);
    check("t1_sel", spi_sel, 1);
    check("t1_nostart", spi_start, 0);
    tick();
    check("t1_start0", spi_start, 1);
    check("t1_tx0", spi_tx_byte, 8'h0A);
    engine_byte("t1_b0", 8'hF0, 2, 8'h0A);
    check("t1_ack0", ack, 3'b001);
    check("t1_rx0", rx_data, 8'hF0);
    check("t1_sel_hold", spi_sel, 1);
    tx_data = 24'h00005C; last = 3'b001;
    wait_start("t1_b1", 8'h5C);
    engine_byte("t1_b1", 8'h0F, 2, 8'h5C);
    check("t1_ack1", ack, 3'b001);
    check("t1_rx1", rx_data, 8'h0F);
    check("t1_sel_drop", spi_sel, 0);
    check("t1_gnt_drop", gnt, 0);
    req = '0;
    n = 0;
    while (dbg_state == ST_RELEASE && n < 20) begin
      n++;
      tick();
    end
    check("t1_gap_len", n, 4);
    check("t1_idle", dbg_state, ST_IDLE);
    check("t1_sel_drops", sel_drops - d0, 1);
    check("t1_starts", n_start - s0, 2);

    // 2: all three request after reset, one byte each
    rst = 1'b1; tick(); rst = 1'b0;
    s0 = n_start; a0 = n_ack;
    req = 3'b111; last = 3'b111; tx_data = 24'hC3B2A1;
    run_txn("t2_r0", 3'b001, 8'hA1, 8'h11, 1'b0);
    run_txn("t2_r1", 3'b010, 8'hB2, 8'h22, 1'b1);
    run_txn("t2_r2", 3'b100, 8'hC3, 8'h33, 1'b1);
    repeat (20) tick();
    check("t2_acks", n_ack - a0, 3);
    check("t2_starts", n_start - s0, 3);

    // 3: owner 1 releases, then 0 and 1 request together
    req = 3'b010; last = 3'b011; tx_data = 24'h002120;
    run_txn("t3_r1", 3'b010, 8'h21, 8'h44, 1'b0);
    req = 3'b011;
    run_txn("t3_r0", 3'b001, 8'h20, 8'h55, 1'b1);
    run_txn("t3_r1b", 3'b010, 8'h21, 8'h66, 1'b1);

    // 4: requester 2 abandons a transaction
    req = 3'b100; last = 3'b000; tx_data = 24'h330000;
    run_txn("t4", 3'b100, 8'h33, 8'h77, 1'b0);
    s0 = n_start;
    n = 0;
    while (terr == 3'b000 && n < 400) begin
      tick();
      n++;
    end
    check("t4_to_delay", n, 255);
    check("t4_terr", terr, 3'b100);
    check("t4_gnt", gnt, 0);
    check("t4_sel", spi_sel, 0);
    tick();
    check("t4_terr_pulse", terr, 0);
    repeat (30) tick();
    check("t4_nostart", n_start - s0, 0);

    // 5: engine busy for 10 cycles while in ISSUE
    spi_busy = 1'b1;
    req = 3'b001; last = 3'b001; tx_data = 24'h000077;
    wait_gnt("t5", 3'b001);
    s0 = n_start;
    seen = 1'b0;
    repeat (10) begin
      tick();
      if (spi_start) seen = 1'b1;
    end
    check("t5_no_start_busy", seen, 0);
    spi_busy = 1'b0;
    tick();
    check("t5_start", spi_start, 1);
    check("t5_tx", spi_tx_byte, 8'h77);
    engine_byte("t5", 8'h88, 3, 8'h77);
    check("t5_ack", ack, 3'b001);
    check("t5_starts", n_start - s0, 1);
    req = '0;
    repeat (10) tick();

    // 6: reset during WAIT_DONE, stale DONE, then fresh request
    req = 3'b001; last = 3'b001; tx_data = 24'h000011;
    wait_start("t6", 8'h11);
    spi_busy = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; spi_busy = 1'b0; req = '0;
    check("t6_gnt", gnt, 0);
    check("t6_sel", spi_sel, 0);
    check("t6_start", spi_start, 0);
    check("t6_txb", spi_tx_byte, 0);
    check("t6_state", dbg_state, ST_IDLE);
    spi_done = 1'b1; spi_rx_byte = 8'hEE;
    tick();
    spi_done = 1'b0; spi_rx_byte = '0;
    check("t6_stale_ack", ack, 0);
    check("t6_stale_rx", rx_data, 0);
    req = 3'b100; last = 3'b100; tx_data = 24'h440000;
    tick();
    check("t6_gnt_lat", gnt, 3'b100);
    wait_start("t6_new", 8'h44);
    engine_byte("t6_new", 8'h99, 2, 8'h44);
    check("t6_ack", ack, 3'b100);
    check("t6_rx", rx_data, 8'h99);
    req = '0;
    repeat (10) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
